// File: rtl/ysyx_23060332_ifq.sv
// Instruction fetch queue between the fetch and decode stages.
// Buffers {pc, inst} pairs in a small circular store addressed by a
// read/write pointer pair with an extra wrap bit. A flush from execute
// (taken jump) drops every buffered wrong-path instruction.
//
// Optional feature: define YSYX_23060332_IFQ_BYPASS_EN to let an
// instruction offered to an empty queue appear on the output in the same
// cycle (and pass straight through if decode takes it). Without the macro
// there is no combinational path from in_* to out_*.
module ysyx_23060332_ifq #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_pc,
    input  logic [DW-1:0]            in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            out_pc,
    output logic [DW-1:0]            out_inst,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;

    // Entry storage; deliberately not reset, only the pointers define content.
    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          bypass_show;
    logic          bypass_take;
    logic [AW-1:0] head_pc;
    logic [DW-1:0] head_inst;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[IW-1:0] == rptr_q[IW-1:0]) && (wptr_q[IW] != rptr_q[IW]);

    assign head_pc   = pc_mem[rptr_q[IW-1:0]];
    assign head_inst = inst_mem[rptr_q[IW-1:0]];

`ifdef YSYX_23060332_IFQ_BYPASS_EN
    // An offer into an empty queue is shown to decode immediately; if decode
    // takes it in the same cycle it never touches storage.
    assign bypass_show = empty && in_valid && !flush && !rst;
    assign bypass_take = bypass_show && out_ready;
`else
    assign bypass_show = 1'b0;
    assign bypass_take = 1'b0;
`endif

    // Full blocks a push even when a pop happens in the same cycle.
    assign in_ready  = !full && !rst;
    assign out_valid = (!empty || bypass_show) && !flush;

    // A flush silently drops a push even though in_ready may be high.
    assign push = in_valid && in_ready && !flush && !bypass_take;
    assign pop  = !empty && out_valid && out_ready;

    assign out_pc   = !empty ? head_pc   : (bypass_show ? in_pc   : '0);
    assign out_inst = !empty ? head_inst : (bypass_show ? in_inst : '0);

    // Occupancy falls out of the pointer difference modulo 2^PW.
    assign count = wptr_q - rptr_q;

    // Next pointer values: flush clears both, otherwise advance on push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry write at the current write index on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr_q[IW-1:0]]   <= in_pc;
            inst_mem[wptr_q[IW-1:0]] <= in_inst;
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_ifq.sv
// Self-checking bench for ysyx_23060332_ifq: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model. Honors YSYX_23060332_IFQ_BYPASS_EN.
module tb_ysyx_23060332_ifq;
    localparam int DEPTH = 4;
`ifdef YSYX_23060332_IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        flush;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;
    bit checks_on = 1'b0;

    // Reference model: the queue contents, oldest first, as {pc, inst}.
    logic [63:0] mq[$];

    ysyx_23060332_ifq #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at the clock edge from the inputs that were held in the cycle.
    always @(posedge clk) begin
        bit byp, pop, push;
        byp  = BYP && mq.size() == 0 && in_valid && !flush && !rst && out_ready;
        pop  = !rst && !flush && mq.size() > 0 && out_ready;
        push = !rst && !flush && in_valid && mq.size() < DEPTH && !byp;
        if (byp) $display("pass pc=%h inst=%h", in_pc, in_inst);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (pop) begin
                $display("pop  pc=%h inst=%h", mq[0][63:32], mq[0][31:0]);
                void'(mq.pop_front());
            end
            if (push) mq.push_back({in_pc, in_inst});
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checks_on) begin
            bit          show;
            logic [31:0] epc, einst;
            show  = BYP && mq.size() == 0 && in_valid && !flush && !rst;
            epc   = 32'h0;
            einst = 32'h0;
            if (mq.size() > 0) begin
                epc   = mq[0][63:32];
                einst = mq[0][31:0];
            end else if (show) begin
                epc   = in_pc;
                einst = in_inst;
            end
            chk("in_ready",  64'(in_ready),  64'(!rst && mq.size() < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(!flush && (mq.size() > 0 || show)));
            chk("count",     64'(count),     64'(mq.size()));
            chk("out_pc",    64'(out_pc),    64'(epc));
            chk("out_inst",  64'(out_inst),  64'(einst));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = 32'h00000013;
        out_ready = rdy;
        flush     = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checks_on = 1'b1;
        step();
        rst = 1'b0;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_in_ready",  64'(in_ready),  64'h1);
        chk("reset_count",     64'(count),     64'h0);
        chk("reset_out_inst",  64'(out_inst),  64'h0);
        step();

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h80000000 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h80000010, 1'b0, 1'b0);
        #2;
        chk("full_count",    64'(count),    64'h4);
        chk("full_in_ready", 64'(in_ready), 64'h0);
        chk("full_head_pc",  64'(out_pc),   64'h80000000);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("fifth_rejected", 64'(count), 64'h4);

        // Drain in order.
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_pc", 64'(out_pc), 64'(32'h80000000 + 32'(4 * i)));
            step();
        end
        #2;
        chk("drained_valid", 64'(out_valid), 64'h0);
        chk("drained_count", 64'(count),     64'h0);

        // Concurrent push/pop across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h80000000 + 32'(4 * i), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("wrap_count", 64'(count), BYP ? 64'h0 : 64'h1);
        if (!BYP) chk("wrap_last_pc", 64'(out_pc), 64'h80000024);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h80000080 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h80000100, 1'b0, 1'b1);
        #2;
        chk("flush_cycle_valid", 64'(out_valid), 64'h0);
        step();
        drive(1'b1, 32'h80000200, 1'b0, 1'b0);
        #2;
        chk("post_flush_count", 64'(count),     64'h0);
        chk("post_flush_valid", 64'(out_valid), BYP ? 64'h1 : 64'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("post_flush_head", 64'(out_pc), 64'h80000200);
        chk("post_flush_cnt1", 64'(count),  64'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();

        // Bypass behaviour on an empty queue.
        drive(1'b1, 32'h80000040, 1'b1, 1'b0);
        #2;
        chk("byp_same_valid", 64'(out_valid), BYP ? 64'h1 : 64'h0);
        if (BYP) chk("byp_same_pc", 64'(out_pc), 64'h80000040);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("byp_next_count", 64'(count),     BYP ? 64'h0 : 64'h1);
        chk("byp_next_valid", 64'(out_valid), BYP ? 64'h0 : 64'h1);
        if (!BYP) chk("byp_next_pc", 64'(out_pc), 64'h80000040);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_pc     = $urandom;
            in_inst   = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checks_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
